// File: rtl/sub_arbiter.sv
// Round-robin front end that time-shares one bitwise-inverter datapath (sub)
// between NREQ requesters and returns each result tagged with its requester id.

module sub #(
  parameter type TYPE_t = logic
) (
  input  TYPE_t i_a,
  output TYPE_t o_y
);
  assign o_y = ~i_a;
endmodule

module sub_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy,
  output logic [15:0]           done_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDW-1:0]   r_last_grant;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   w_gidx;
  logic             w_found;
  logic [NREQ-1:0]  w_grant;
  logic [WIDTH-1:0] r_op;
  logic [WIDTH-1:0] r_rsp_data;
  logic [WIDTH-1:0] w_sel_data;
  logic [WIDTH-1:0] w_sub_y;
  logic             r_rsp_valid;
  logic             r_busy;
  logic [15:0]      r_done_count;

  // Requester index k positions above base, wrapping modulo NREQ.
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end else begin
      sum = sum;
    end
    return IDW'(sum);
  endfunction

  // Search upward from the last winner so the previous grantee ranks last.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && req_valid[rr_index(r_last_grant, k)]) begin
        w_found = 1'b1;
        w_gidx  = rr_index(r_last_grant, k);
      end else begin
        w_found = w_found;
      end
    end
  end

  assign w_grant    = w_found ? (NREQ'(1) << w_gidx) : '0;
  assign req_ready  = ((r_state == ST_IDLE) && !reset) ? w_grant : '0;
  assign w_sel_data = req_data[int'(w_gidx)*WIDTH +: WIDTH];

  sub #(.TYPE_t(logic [WIDTH-1:0])) u_sub (
    .i_a (r_op),
    .o_y (w_sub_y)
  );

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_next = ST_EXEC;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_RESP;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State, operand/result capture and the saturating completion counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= IDW'(NREQ - 1);
      r_id         <= '0;
      r_op         <= '0;
      r_rsp_data   <= '0;
      r_rsp_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done_count <= 16'd0;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next != ST_IDLE);
      r_rsp_valid <= (w_next == ST_RESP);
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_op         <= w_sel_data;
            r_id         <= w_gidx;
            r_last_grant <= w_gidx;
          end
        end
        ST_EXEC: r_rsp_data <= w_sub_y;
        ST_RESP: begin
          if (rsp_ready && (r_done_count != 16'hFFFF)) begin
            r_done_count <= r_done_count + 16'd1;
          end
        end
        default: r_rsp_data <= r_rsp_data;
      endcase
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_id     = r_id;
  assign busy       = r_busy;
  assign done_count = r_done_count;

endmodule

// File: tb/tb_sub_arbiter.sv
// Bench for sub_arbiter: directed scenarios plus random traffic checked
// against a transaction-level round-robin model.

module tb_sub_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           busy;
  logic [15:0]    done_count;

  logic [0:0]  req_valid1;
  logic [0:0]  req_ready1;
  logic [15:0] req_data1;
  logic        rsp_valid1;
  logic        rsp_ready1;
  logic [15:0] rsp_data1;
  logic [0:0]  rsp_id1;
  logic        busy1;
  logic [15:0] done1;

  always #5 clk = ~clk;

  sub_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy), .done_count(done_count)
  );

  sub_arbiter #(.NREQ(1), .WIDTH(16)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_data(req_data1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_data(rsp_data1), .rsp_id(rsp_id1), .busy(busy1), .done_count(done1)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Model state: pending operands per requester and the one in-flight job.
  bit           pv[N];
  logic [W-1:0] pd[N];
  bit           rdy;
  bit           keep;
  int           last;
  bit           inflight;
  int           age;
  int           eid;
  logic [W-1:0] edata;
  int           cnt;
  int           cyc;
  int           hs_cyc;
  int           acc_id[$];
  int           acc_cyc[$];
  logic [W-1:0] rsp_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = pv[i];
      req_data[i*W +: W]   = pd[i];
    end
    rsp_ready = rdy;
  endtask

  function automatic int winner();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (pv[i]) return i;
    end
    return -1;
  endfunction

  // One clock cycle: apply inputs, compare against the model, advance.
  task automatic step();
    int w;
    logic [N-1:0] exp_rr;
    drive();
    #1;
    chk("done_count", 32'(done_count), 32'(cnt));
    if (!inflight) begin
      w = winner();
      exp_rr = '0;
      if (w >= 0) exp_rr[w] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rr));
      chk("busy_idle", 32'(busy), 32'd0);
      chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
      if (w >= 0) begin
        inflight = 1'b1;
        age      = 0;
        eid      = w;
        edata    = ~pd[w];
        last     = w;
        if (!keep) pv[w] = 1'b0;
        acc_id.push_back(w);
        acc_cyc.push_back(cyc);
      end
    end else begin
      age++;
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      chk("busy", 32'(busy), 32'd1);
      if (age == 1) begin
        chk("rsp_valid_exec", 32'(rsp_valid), 32'd0);
      end else begin
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_data", 32'(rsp_data), 32'(edata));
        chk("rsp_id", 32'(rsp_id), 32'(eid));
        if (rdy) begin
          inflight = 1'b0;
          hs_cyc   = cyc;
          rsp_log.push_back(edata);
          if (cnt < 65535) cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive();
    @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_done", 32'(done_count), 32'd0);
    reset    = 1'b0;
    inflight = 1'b0;
    last     = N - 1;
    cnt      = 0;
    acc_id.delete();
    acc_cyc.delete();
    rsp_log.delete();
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
  endtask

  task automatic drain();
    pv_clear_loop: for (int k = 0; k < 12 && inflight; k++) step();
    chk("drain", 32'(inflight), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1;
    int base;
    reset = 1'b1; rdy = 1'b0; keep = 1'b0; cyc = 0; hs_cyc = 0;
    req_valid1 = 1'b0; req_data1 = 16'h0000; rsp_ready1 = 1'b0;
    clear_reqs();
    drive();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single request from requester 2.
    pv[2] = 1'b1; pd[2] = 8'h5A; rdy = 1'b1;
    repeat (4) step();
    chk("single_rsp", 32'(rsp_log.size() > 0 ? rsp_log[0] : 8'h00), 32'h0000_00A5);
    chk("single_id", 32'(acc_id.size() > 0 ? acc_id[0] : 99), 32'd2);
    chk("single_count", 32'(done_count), 32'd1);

    // Round-robin with all four requesters held valid.
    do_reset();
    keep = 1'b1;
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b1;
      pd[i] = 8'(i * 8'h11);
    end
    repeat (15) step();
    keep = 1'b0;
    clear_reqs();
    drain();
    for (int i = 0; i < 5; i++) chk("rr_order", 32'(acc_id[i]), 32'(i % 4));
    for (int i = 0; i < 4; i++) chk("rr_data", 32'(rsp_log[i]), 32'(8'hFF - 8'(i * 8'h11)));
    for (int i = 1; i < 5; i++) chk("rr_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);

    // Backpressure while requester 1 waits.
    do_reset();
    pv[0] = 1'b1; pd[0] = 8'h3C; rdy = 1'b0;
    step();
    step();
    pv[1] = 1'b1; pd[1] = 8'h77;
    repeat (5) step();
    rdy = 1'b1;
    step();
    step();
    chk("bp_next_id", 32'(acc_id[acc_id.size()-1]), 32'd1);
    chk("bp_next_cyc", 32'(acc_cyc[acc_id.size()-1]), 32'(hs_cyc + 1));
    drain();

    // Reset during EXEC discards the transaction.
    do_reset();
    pv[1] = 1'b1; pd[1] = 8'h42; rdy = 1'b1;
    step();
    do_reset();
    pv[0] = 1'b1; pd[0] = 8'h10;
    pv[3] = 1'b1; pd[3] = 8'h30;
    step();
    chk("mid_rst_first", 32'(acc_id[0]), 32'd0);
    repeat (6) step();
    drain();
    chk("mid_rst_rsps", 32'(rsp_log.size()), 32'd2);

    // Random traffic.
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 3) == 0) begin
          pv[i] = 1'b1;
          pd[i] = W'($urandom);
        end else if (pv[i] && $urandom_range(0, 15) == 0) begin
          pv[i] = 1'b0;
        end
      end
      rdy = ($urandom_range(0, 2) != 0);
      step();
    end
    clear_reqs();
    rdy = 1'b1;
    drain();

    // Saturation of the completion counter.
    force dut.r_done_count = 16'hFFFD;
    #1;
    release dut.r_done_count;
    cnt  = 65533;
    keep = 1'b1;
    pv[2] = 1'b1; pd[2] = 8'h9C;
    repeat (24) step();
    keep = 1'b0;
    clear_reqs();
    drain();
    chk("sat_final", 32'(done_count), 32'h0000_FFFF);

    // Single-requester, 16-bit instance.
    do_reset();
    req_valid1 = 1'b1; req_data1 = 16'h00FF; rsp_ready1 = 1'b1;
    n1 = 0;
    for (int t = 0; t < 12; t++) begin
      #1;
      if (rsp_valid1) begin
        chk("n1_data", 32'(rsp_data1), 32'h0000_FF00);
        chk("n1_id", 32'(rsp_id1), 32'd0);
        n1++;
      end
      @(posedge clk);
      #1;
    end
    chk("n1_count", 32'(n1), 32'd4);
    base = int'(done1);
    chk("n1_done", 32'(base), 32'd4);
    req_valid1 = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
